// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and helpers for the byte-serial RAM port arbiter.
package mem_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
    ArbRd   = 2'd1,
    ArbWr   = 2'd2,
    ArbDone = 2'd3
  } arb_state_e;

  typedef enum logic {
    OwnIf  = 1'b0,
    OwnMem = 1'b1
  } owner_e;

  localparam logic [1:0] MemSizeByte = 2'b00;
  localparam logic [1:0] MemSizeHalf = 2'b01;
  localparam logic [1:0] MemSizeWord = 2'b10;

  // Number of byte beats for a MEM access size; 2'b11 is treated as a word.
  function automatic logic [CNT_W-1:0] size_beats(input logic [1:0] size);
    case (size)
      MemSizeByte: return CNT_W'(1);
      MemSizeHalf: return CNT_W'(2);
      MemSizeWord: return CNT_W'(4);
      default:     return CNT_W'(4);
    endcase
  endfunction

  function automatic logic [7:0] byte_lane(input logic [DATA_W-1:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates IF and MEM onto a single byte-wide synchronous RAM port,
// serialising little-endian accesses into byte beats.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              flush,
  output logic              if_done,
  output logic [DATA_W-1:0] if_inst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_size,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic              busy
);

  arb_state_e        state, state_nxt;
  owner_e            owner, owner_nxt;
  logic              we, we_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [CNT_W-1:0]  n, n_nxt;
  logic [CNT_W-1:0]  issue, issue_nxt;
  logic [CNT_W-1:0]  cap, cap_nxt;
  logic [DATA_W-1:0] wdata, wdata_nxt;
  logic [DATA_W-1:0] rbuf, rbuf_nxt;
  logic              beat_rd, beat_rd_nxt;
  logic              din_vld, din_vld_nxt;
  logic              grant;
  logic [ADDR_W-1:0] ram_a_nxt;
  logic              ram_wr_nxt;
  logic [7:0]        ram_dout_nxt;
  logic              if_done_nxt, mem_done_nxt;
  logic [DATA_W-1:0] if_inst_nxt, mem_rdata_nxt;

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ArbIdle;
      owner     <= OwnIf;
      we        <= 1'b0;
      addr      <= '0;
      n         <= '0;
      issue     <= '0;
      cap       <= '0;
      wdata     <= '0;
      rbuf      <= '0;
      beat_rd   <= 1'b0;
      din_vld   <= 1'b0;
      ram_a     <= '0;
      ram_wr    <= 1'b0;
      ram_dout  <= '0;
      if_done   <= 1'b0;
      if_inst   <= '0;
      mem_done  <= 1'b0;
      mem_rdata <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      we        <= we_nxt;
      addr      <= addr_nxt;
      n         <= n_nxt;
      issue     <= issue_nxt;
      cap       <= cap_nxt;
      wdata     <= wdata_nxt;
      rbuf      <= rbuf_nxt;
      beat_rd   <= beat_rd_nxt;
      din_vld   <= din_vld_nxt;
      ram_a     <= ram_a_nxt;
      ram_wr    <= ram_wr_nxt;
      ram_dout  <= ram_dout_nxt;
      if_done   <= if_done_nxt;
      if_inst   <= if_inst_nxt;
      mem_done  <= mem_done_nxt;
      mem_rdata <= mem_rdata_nxt;
      busy      <= (state_nxt != ArbIdle);
    end
  end

  // Next-state, beat sequencing and byte assembly.
  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    we_nxt        = we;
    addr_nxt      = addr;
    n_nxt         = n;
    issue_nxt     = issue;
    cap_nxt       = cap;
    wdata_nxt     = wdata;
    rbuf_nxt      = rbuf;
    beat_rd_nxt   = 1'b0;
    din_vld_nxt   = 1'b0;
    grant         = 1'b0;
    ram_a_nxt     = ram_a;
    ram_wr_nxt    = 1'b0;
    ram_dout_nxt  = ram_dout;
    if_done_nxt   = 1'b0;
    if_inst_nxt   = if_inst;
    mem_done_nxt  = 1'b0;
    mem_rdata_nxt = mem_rdata;

    case (state)
      ArbIdle: begin
        if (mem_req) begin
          grant     = 1'b1;
          owner_nxt = OwnMem;
          we_nxt    = mem_we;
          addr_nxt  = mem_addr;
          n_nxt     = size_beats(mem_size);
          wdata_nxt = mem_wdata;
        end else if (if_req && !flush) begin
          grant     = 1'b1;
          owner_nxt = OwnIf;
          we_nxt    = 1'b0;
          addr_nxt  = if_addr;
          n_nxt     = CNT_W'(4);
          wdata_nxt = '0;
        end
        // Beat 0 is launched with the grant so it is on ram_a in the first RD/WR cycle.
        if (grant) begin
          issue_nxt = CNT_W'(1);
          cap_nxt   = '0;
          rbuf_nxt  = '0;
          ram_a_nxt = addr_nxt;
          if (we_nxt) begin
            state_nxt    = ArbWr;
            ram_wr_nxt   = 1'b1;
            ram_dout_nxt = wdata_nxt[7:0];
          end else begin
            state_nxt   = ArbRd;
            beat_rd_nxt = 1'b1;
          end
        end
      end

      ArbRd: begin
        if (owner == OwnIf && flush) begin
          state_nxt = ArbIdle;
        end else begin
          din_vld_nxt = beat_rd;
          if (issue < n) begin
            ram_a_nxt   = addr + ADDR_W'(issue);
            issue_nxt   = issue + CNT_W'(1);
            beat_rd_nxt = 1'b1;
          end
          // ram_din carries the byte addressed in the previous cycle.
          if (din_vld) begin
            rbuf_nxt = rbuf | (DATA_W'(ram_din) << {cap[1:0], 3'b000});
            cap_nxt  = cap + CNT_W'(1);
            if (cap_nxt == n) begin
              state_nxt = ArbDone;
              if (owner == OwnIf) begin
                if_done_nxt = 1'b1;
                if_inst_nxt = rbuf_nxt;
              end else begin
                mem_done_nxt  = 1'b1;
                mem_rdata_nxt = rbuf_nxt;
              end
            end
          end
        end
      end

      ArbWr: begin
        if (issue < n) begin
          ram_a_nxt    = addr + ADDR_W'(issue);
          ram_wr_nxt   = 1'b1;
          ram_dout_nxt = byte_lane(wdata, issue[1:0]);
          issue_nxt    = issue + CNT_W'(1);
        end else begin
          state_nxt    = ArbDone;
          mem_done_nxt = 1'b1;
        end
      end

      ArbDone: state_nxt = ArbIdle;

      default: state_nxt = ArbIdle;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers push expected beats and done
// responses from a byte-array memory model; a negedge monitor checks them.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        flush = 1'b0;
  logic        if_done;
  logic [31:0] if_inst;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [1:0]  mem_size = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .flush(flush),
    .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_size(mem_size), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    case (a)
      16'h1000: return 8'h13;
      16'h1001: return 8'h05;
      16'h1002, 16'h1003: return 8'h00;
      16'h0020: return 8'hAA;
      16'h0021: return 8'hBB;
      default:  return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5C;
    endcase
  endfunction

  // Synchronous byte RAM (64 KiB image, upper address bits ignored); bit 8 marks written.
  logic [8:0] ram_mem [65536];
  logic       ram_clr = 1'b1;
  always @(posedge clk) begin
    ram_din <= ram_mem[ram_a[15:0]][8] ? ram_mem[ram_a[15:0]][7:0] : init_byte(ram_a[15:0]);
    if (ram_clr) begin
      for (int i = 0; i < 65536; i++) ram_mem[i] <= '0;
    end else if (ram_wr) begin
      ram_mem[ram_a[15:0]] <= {1'b1, ram_dout};
    end
  end

  // Reference memory, updated in program order as transactions are planned.
  logic [7:0] ref_mem [65536];

  typedef struct { int cyc; logic [31:0] a; bit wr; logic [7:0] d; } beat_t;
  typedef struct { int cyc; bit is_if; bit chk; logic [31:0] data; } done_t;
  beat_t beat_q[$];
  done_t done_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  task automatic push_beat(input int c, input logic [31:0] a, input bit wr, input logic [7:0] d);
    beat_t b;
    b.cyc = c; b.a = a; b.wr = wr; b.d = d;
    beat_q.push_back(b);
  endtask

  // Expected beats and response for a transaction whose request is sampled in cycle t0.
  task automatic plan(input bit is_if, input bit we, input logic [31:0] a, input int n,
                      input logic [31:0] wd, input int t0, output int dcyc);
    done_t e;
    logic [31:0] data;
    logic [31:0] ai;
    data = '0;
    for (int i = 0; i < n; i++) begin
      ai = a + 32'(i);
      push_beat(t0 + 1 + i, ai, we, we ? wd[8*i +: 8] : 8'h00);
      if (we) ref_mem[ai[15:0]] = wd[8*i +: 8];
      else    data[8*i +: 8] = ref_mem[ai[15:0]];
    end
    dcyc = t0 + n + (we ? 1 : 2);
    e.cyc = dcyc; e.is_if = is_if; e.chk = !we; e.data = data;
    done_q.push_back(e);
  endtask

  task automatic wait_done(input bit is_if);
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (is_if ? (if_done === 1'b1) : (mem_done === 1'b1)) break;
    end
    if (k == 40) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no %s done expected one (cycle %0d)", is_if ? "if" : "mem", cyc);
    end
  endtask

  task automatic do_if(input logic [31:0] a);
    int d;
    @(negedge clk);
    if_addr = a; if_req = 1'b1;
    plan(1'b1, 1'b0, a, 4, 32'h0, cyc, d);
    wait_done(1'b1);
    if_req = 1'b0;
  endtask

  task automatic do_mem(input bit we, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int d;
    @(negedge clk);
    mem_we = we; mem_addr = a; mem_size = sz; mem_wdata = wd; mem_req = 1'b1;
    plan(1'b0, we, a, nbytes(sz), wd, cyc, d);
    wait_done(1'b0);
    mem_req = 1'b0;
  endtask

  // Both request together: MEM first, IF in the IDLE cycle after MEM's done.
  task automatic do_pair(input bit we, input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] wd, input logic [31:0] ia);
    int d, d2;
    @(negedge clk);
    mem_we = we; mem_addr = a; mem_size = sz; mem_wdata = wd; mem_req = 1'b1;
    if_addr = ia; if_req = 1'b1;
    plan(1'b0, we, a, nbytes(sz), wd, cyc, d);
    plan(1'b1, 1'b0, ia, 4, 32'h0, d + 1, d2);
    wait_done(1'b0);
    mem_req = 1'b0;
    wait_done(1'b1);
    if_req = 1'b0;
  endtask

  // Monitor: timed RAM beats and done responses.
  always @(negedge clk) begin
    beat_t b;
    done_t e;
    if (beat_q.size() > 0 && beat_q[0].cyc <= cyc) begin
      b = beat_q.pop_front();
      chk("beat_cycle", 32'(cyc), 32'(b.cyc));
      chk("ram_a", ram_a, b.a);
      chk("ram_wr", 32'(ram_wr), 32'(b.wr));
      if (b.wr) chk("ram_dout", 32'(ram_dout), 32'(b.d));
    end else begin
      chk("ram_wr_idle", 32'(ram_wr), 32'd0);
    end
    if (if_done || mem_done) begin
      if (done_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got if_done=%b mem_done=%b expected none (cycle %0d)",
                 if_done, mem_done, cyc);
      end else begin
        e = done_q.pop_front();
        chk("done_if", 32'(if_done), 32'(e.is_if));
        chk("done_mem", 32'(mem_done), 32'(!e.is_if));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        if (e.chk && e.is_if)  chk("if_inst", if_inst, e.data);
        if (e.chk && !e.is_if) chk("mem_rdata", mem_rdata, e.data);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ram_a"}, ram_a, 32'h0);
    chk({tag, "_ram_wr"}, 32'(ram_wr), 32'h0);
    chk({tag, "_ram_dout"}, 32'(ram_dout), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_if_done"}, 32'(if_done), 32'h0);
    chk({tag, "_mem_done"}, 32'(mem_done), 32'h0);
    chk({tag, "_if_inst"}, if_inst, 32'h0);
    chk({tag, "_mem_rdata"}, mem_rdata, 32'h0);
  endtask

  initial begin
    int c, d, kind;
    logic [31:0] a, wd, ia;
    logic [1:0]  sz;

    for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(16'(i));
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    ram_clr = 1'b0;
    rst = 1'b1;

    do_if(32'h0000_1000);
    do_pair(1'b0, 32'h0000_0020, 2'b01, 32'h0, 32'h0000_1000);
    do_mem(1'b1, 32'h0000_0007, 2'b00, 32'h1234_56EF);
    do_mem(1'b0, 32'h0000_0007, 2'b00, 32'h0);
    do_mem(1'b1, 32'hFFFF_FFFE, 2'b10, 32'hA1B2_C3D4);
    do_mem(1'b0, 32'hFFFF_FFFE, 2'b11, 32'h0);

    // flush mid-read with a MEM request waiting
    @(negedge clk);
    c = cyc;
    if_addr = 32'h0000_2000; if_req = 1'b1;
    for (int i = 0; i < 3; i++) push_beat(c + 1 + i, 32'h0000_2000 + 32'(i), 1'b0, 8'h00);
    @(negedge clk);
    mem_we = 1'b0; mem_addr = 32'h0000_0040; mem_size = 2'b10; mem_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1; if_req = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    chk("busy_after_flush", 32'(busy), 32'h0);
    plan(1'b0, 1'b0, 32'h0000_0040, 4, 32'h0, cyc, d);
    wait_done(1'b0);
    mem_req = 1'b0;

    // flush coincident with an IF grant suppresses it
    @(negedge clk);
    if_addr = 32'h0000_1000; if_req = 1'b1; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("busy_flush_idle", 32'(busy), 32'h0);
    plan(1'b1, 1'b0, 32'h0000_1000, 4, 32'h0, cyc, d);
    wait_done(1'b1);
    if_req = 1'b0;

    // reset during beat 2 of a word store; held request restarts
    @(negedge clk);
    c = cyc;
    mem_we = 1'b1; mem_addr = 32'h0000_0300; mem_size = 2'b10; mem_wdata = 32'hCAFE_F00D; mem_req = 1'b1;
    push_beat(c + 1, 32'h0000_0300, 1'b1, 8'h0D);
    push_beat(c + 2, 32'h0000_0301, 1'b1, 8'hF0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("midreset");
    rst = 1'b1;
    plan(1'b0, 1'b1, 32'h0000_0300, 4, 32'hCAFE_F00D, cyc, d);
    wait_done(1'b0);
    mem_req = 1'b0;
    do_mem(1'b0, 32'h0000_0300, 2'b10, 32'h0);

    for (int t = 0; t < 80; t++) begin
      kind = int'($urandom_range(0, 3));
      a  = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : 32'($urandom);
      ia = 32'($urandom);
      wd = 32'($urandom);
      sz = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      case (kind)
        0: do_if(a);
        1: do_mem(1'b0, a, sz, 32'h0);
        2: do_mem(1'b1, a, sz, wd);
        default: do_pair(1'($urandom_range(0, 1)), a, sz, wd, ia);
      endcase
    end

    repeat (5) @(negedge clk);
    chk("done_q_empty", 32'(done_q.size()), 32'h0);
    chk("beat_q_empty", 32'(beat_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences the CPU's single byte-wide synchronous RAM port between two requesters: instruction fetch (IF, 32-bit reads) and the MEM stage (loads and stores of byte, half or word). The address for MEM requests is the one computed in EX. The block sits between the IF/MEM stages and the RAM. It serialises each access into byte beats, assembles or splits little-endian words, and grants the port by fixed priority with no pre-emption.

## Interface
Parameters:
- ADDR_W, 32, width of all addresses (matches `MemAddrBus`).

Ports:
- clk  in  1  clock; every register updates on its rising edge.
- rst  in  1  synchronous, active-low reset.
- if_req  in  1  IF read request; level, held until if_done.
- if_addr  in  32  IF fetch address.
- flush  in  1  branch/jump redirect; cancels an IF transaction.
- if_done  out  1  one-cycle pulse; if_inst valid.
- if_inst  out  32  fetched instruction.
- mem_req  in  1  MEM-stage request; level, held until mem_done.
- mem_we  in  1  1 = store, 0 = load.
- mem_addr  in  32  load/store address.
- mem_size  in  2  00 = byte, 01 = half, 10/11 = word.
- mem_wdata  in  32  store data; low bytes used.
- mem_done  out  1  one-cycle pulse; load or store complete.
- mem_rdata  out  32  load data, zero-extended (sign extension is done in MEM).
- ram_a  out  32  RAM byte address.
- ram_wr  out  1  RAM write enable.
- ram_dout  out  8  RAM write byte.
- ram_din  in  8  RAM read byte; valid one cycle after its address.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, RD, WR, DONE.
- **Grant (IDLE only):** mem_req has priority over if_req.
  - On grant, latch: owner, address, n (1/2/4 bytes; IF is always 4), write data, direction.
  - Clear the beat counter `issue` and the capture counter `cap`.
- **RD:**
  - Each cycle with issue < n: drive ram_a = addr + issue, ram_wr = 0, then increment issue.
  - Each cycle after the first one in RD, ram_din is byte `cap`; store it in bits [8·cap+7 : 8·cap] and increment cap.
  - When cap reaches n: go to DONE and assert the owner's done and data. Unused upper bytes are 0.
- **WR:**
  - Each cycle: ram_a = addr + issue, ram_wr = 1, ram_dout = wdata[8·issue+7 : 8·issue].
  - After the n-th beat, go to DONE.
- **DONE:** exactly one cycle. The done pulse is high, no grant is made, then return to IDLE.
  - The requester must drop or change its req in the done cycle; req is next sampled in IDLE.
- **Address arithmetic:** ADDR_W-bit, wraps modulo 2^32 (0xFFFFFFFF + 1 = 0x00000000).
- **flush:**
  - Owner is IF, state RD: go to IDLE next cycle, no if_done, ram_wr stays 0, captured data discarded.
  - flush coincident with a grant to IF in IDLE: the grant is suppressed.
  - flush never affects MEM transactions (stores are never aborted).
- **Simultaneous requests in IDLE:** MEM wins and IF waits. After the MEM transaction's DONE cycle, IF is granted in the next IDLE cycle if if_req is still high.
- **Requests while busy:** ignored; the requester holds them.
- **Reset (rst = 0, any state, mid-transaction included):**
  - State ← IDLE; counters ← 0.
  - ram_a = 0, ram_wr = 0, ram_dout = 0.
  - if_done = 0, if_inst = 0, mem_done = 0, mem_rdata = 0, busy = 0.

## Timing
- All outputs are registered; no combinational path from req to ram_*.
- Request sampled high in IDLE at cycle T0 → first beat on ram_a in T1.
- Read of n bytes: beats in T1..Tn, captures in T2..T(n+1), done pulse in T(n+2). A word read has done in T6.
- Write of n bytes: beats in T1..Tn, done pulse in T(n+1). A byte store has done in T2.
- Back-to-back throughput: one transaction every n+3 cycles (reads) or n+2 cycles (writes), including the IDLE sample cycle.
- ram_wr is high only in WR cycles; ram_a holds its last value otherwise.

## Structure
- Add to the shared `defines.v`:
  - state encodings (`ArbIdle`, `ArbRd`, `ArbWr`, `ArbDone`);
  - size codes (`MemSizeByte` = 2'b00, `MemSizeHalf` = 2'b01, `MemSizeWord` = 2'b10);
  - owner codes (`OwnIf`, `OwnMem`).
- No sub-module. The FSM, two 3-bit counters and the byte lane mux are in-line.

## Test plan
- IF word read at 0x00001000, RAM holds 13 05 00 00 → ram_a 0x1000..0x1003 in T1..T4; if_done in T6 with if_inst = 0x00000513.
- mem_req and if_req asserted together; MEM loads a half from 0x20 holding AA BB → mem_done in T4 with mem_rdata = 0x0000BBAA. IF is granted in the following IDLE cycle.
- Byte store of 0x123456EF to 0x7 → one ram_wr beat: ram_a = 0x7, ram_dout = 0xEF; mem_done in T2.
- Word store at 0xFFFFFFFE → ram_a sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001 (wrap).
- flush in T3 of an IF read → state IDLE at T4, if_done never asserted; a pending mem_req is then granted normally.
- rst = 0 during the WR beat 2 of a word store → next cycle all outputs are 0 and the state is IDLE; after release, a held mem_req restarts from beat 0.
